// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: execute-stage mem_op codes and FSM states.
package mem_stage_pkg;

  localparam logic [4:0] OP_LW  = 5'b01100;
  localparam logic [4:0] OP_LH  = 5'b01101;
  localparam logic [4:0] OP_LHU = 5'b01110;
  localparam logic [4:0] OP_LB  = 5'b01111;
  localparam logic [4:0] OP_LBU = 5'b10000;
  localparam logic [4:0] OP_SW  = 5'b10001;
  localparam logic [4:0] OP_SH  = 5'b10010;
  localparam logic [4:0] OP_SB  = 5'b10011;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  // Memory ops occupy one contiguous code range in the execute-stage encoding.
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op >= OP_LW) && (op <= OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the memory-access stage (master) and memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_load_store_align.sv
// Combinational lane logic: alignment check, store byte enables/replication, load extract/extend.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rdata[{addr_lo, 3'b000} +: 8];
    lane_h     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    is_mem     = is_mem_op(op);
    is_store   = 1'b0;
    misaligned = 1'b0;
    be         = '0;
    wdata      = '0;
    load_data  = '0;
    case (op)
      OP_LW: begin
        misaligned = |addr_lo;
        be         = '1;
        load_data  = rdata;
      end
      OP_LH, OP_LHU: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data  = (op == OP_LH) ? {{16{lane_h[15]}}, lane_h} : {16'h0000, lane_h};
      end
      OP_LB, OP_LBU: begin
        be        = 4'b0001 << addr_lo;
        load_data = (op == OP_LB) ? {{24{lane_b[7]}}, lane_b} : {24'h000000, lane_b};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = |addr_lo;
        be         = '1;
        wdata      = store_data;
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
      end
      OP_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, runs one dmem transfer at a time.
// Optional MEM_TIMEOUT_EN adds a dmem_ack watchdog of TIMEOUT_CYCLES (>= 1) wait cycles.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [4:0]                mem_op,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               store_data,
  input  logic [4:0]                rd_in,
  input  logic                      reg_write_in,
  mem_access_stage_if.master        dmem,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic                      wb_reg_write,
  output logic [31:0]               wb_data,
  output logic                      misalign_err,
  output logic                      bus_timeout
);

  state_e      state, state_nx;
  logic [4:0]  op_q;
  logic [1:0]  alo_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic [4:0]  op_sel;
  logic [1:0]  alo_sel;
  logic        a_is_mem, a_is_store, a_misaligned;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_load;
  logic        accept, pass_thru, bad_align, start_mem, ack_hit, tmo_hit;

  // One aligner serves both phases: request generation in IDLE, load extraction in WAIT.
  assign op_sel  = (state == S_WAIT) ? op_q  : mem_op;
  assign alo_sel = (state == S_WAIT) ? alo_q : alu_result[1:0];

  load_store_align u_align (
    .op         (op_sel),
    .addr_lo    (alo_sel),
    .store_data (store_data),
    .rdata      (dmem.dmem_rdata),
    .is_mem     (a_is_mem),
    .is_store   (a_is_store),
    .misaligned (a_misaligned),
    .be         (a_be),
    .wdata      (a_wdata),
    .load_data  (a_load)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end

  assign tmo_hit = (state == S_WAIT) && !dmem.dmem_ack && (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_mem)         state_nx = S_WAIT;
      S_WAIT: if (ack_hit || tmo_hit) state_nx = S_IDLE;
      default:                        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ready_in  = (state == S_IDLE);
    accept    = valid_in && ready_in;
    pass_thru = accept && !a_is_mem;
    bad_align = accept && a_is_mem && a_misaligned;
    start_mem = accept && a_is_mem && !a_misaligned;
    ack_hit   = (state == S_WAIT) && dmem.dmem_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_reg_write    <= 1'b0;
      wb_data         <= '0;
      misalign_err    <= 1'b0;
      bus_timeout     <= 1'b0;
      op_q            <= '0;
      alo_q           <= '0;
      rd_q            <= '0;
      rw_q            <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_timeout  <= 1'b0;
      if (pass_thru) begin
        wb_valid     <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd_in;
        wb_reg_write <= reg_write_in;
      end
      if (bad_align) misalign_err <= 1'b1;
      if (start_mem) begin
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= a_is_store;
        dmem.dmem_addr  <= {alu_result[31:2], 2'b00};
        dmem.dmem_be    <= a_be;
        dmem.dmem_wdata <= a_wdata;
        op_q            <= mem_op;
        alo_q           <= alu_result[1:0];
        rd_q            <= rd_in;
        rw_q            <= reg_write_in && !a_is_store;
      end
      if (ack_hit) begin
        dmem.dmem_req <= 1'b0;
        dmem.dmem_we  <= 1'b0;
        wb_valid      <= 1'b1;
        wb_rd         <= rd_q;
        wb_reg_write  <= rw_q;
        wb_data       <= a_is_store ? '0 : a_load;
      end
      if (tmo_hit) begin
        dmem.dmem_req <= 1'b0;
        dmem.dmem_we  <= 1'b0;
        bus_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; expected writebacks are queued at issue, popped on wb_valid.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [4:0]  mem_op;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_timeout;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .mem_op       (mem_op),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .dmem         (dmem_bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .bus_timeout  (bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
      else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        if (e.chk_data) check("wb_data", wb_data, e.data);
      end
    end
  end

  // Every task below starts and ends 1 time unit after a rising edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    valid_in = 1'b1; mem_op = op; alu_result = addr; store_data = sd;
    rd_in = rd; reg_write_in = rw;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_op = 5'b00011; alu_result = 32'h5555_AAAA; store_data = 32'hA5A5_5A5A;
  endtask

  task automatic do_mem(input string tag, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                        input int unsigned dly, input logic [31:0] rdata, input logic [31:0] exp_data,
                        input logic is_st, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int unsigned low = 0;
    wb_exp_t e;
    e.rd = rd; e.rw = is_st ? 1'b0 : rw; e.data = exp_data; e.chk_data = !is_st;
    sb_q.push_back(e);
    issue(op, addr, sd, rd, rw);
    for (int unsigned i = 0; i < dly; i++) begin
      if (i == dly - 1) begin
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = rdata;
      end
      @(negedge clk);
      if (!ready_in) low++;
      check({tag, "_req"}, 32'(dmem_bus.dmem_req), 32'd1);
      check({tag, "_addr"}, dmem_bus.dmem_addr, {addr[31:2], 2'b00});
      if (i == 0) begin
        check({tag, "_we"}, 32'(dmem_bus.dmem_we), 32'(is_st));
        if (is_st) begin
          check({tag, "_be"}, 32'(dmem_bus.dmem_be), 32'(exp_be));
          check({tag, "_wdata"}, dmem_bus.dmem_wdata, exp_wd);
        end
      end
      @(posedge clk); #1;
    end
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_req_drop"}, 32'(dmem_bus.dmem_req), 32'd0);
    check({tag, "_ready"}, 32'(ready_in), 32'd1);
    check({tag, "_bus_timeout"}, 32'(bus_timeout), 32'd0);
    check({tag, "_busy_cycles"}, low, dly);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; mem_op = '0; alu_result = '0; store_data = '0;
    rd_in = '0; reg_write_in = 1'b0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("rst_be", 32'(dmem_bus.dmem_be), 32'd0);
    check("rst_addr", dmem_bus.dmem_addr, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_timeout", 32'(bus_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_in), 32'd1);
    @(posedge clk); #1;

    // Non-memory op: one-cycle pass-through.
    begin
      wb_exp_t e;
      e.rd = 5'd5; e.rw = 1'b1; e.data = 32'h0000_1234; e.chk_data = 1'b1;
      sb_q.push_back(e);
    end
    issue(5'b00000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    @(negedge clk);
    check("alu_wb_valid", 32'(wb_valid), 32'd1);
    check("alu_no_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("alu_ready", 32'(ready_in), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_wb_pulse", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;

    // ack while idle is ignored; the monitor flags any stray writeback.
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_wb", 32'(wb_valid), 32'd0);
    check("idle_ack_ready", 32'(ready_in), 32'd1);
    @(posedge clk); #1;

    do_mem("lb",  OP_LB,  32'h0000_0103, 32'h0, 5'd7,  1'b1, 3, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 4'h0, 32'h0);
    do_mem("lbu", OP_LBU, 32'h0000_0101, 32'h0, 5'd8,  1'b1, 1, 32'h0000_AB00, 32'h0000_00AB, 1'b0, 4'h0, 32'h0);
    do_mem("lh",  OP_LH,  32'h0000_0102, 32'h0, 5'd9,  1'b1, 2, 32'h8001_7F00, 32'hFFFF_8001, 1'b0, 4'h0, 32'h0);
    do_mem("lhu", OP_LHU, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 1, 32'h1234_F00D, 32'h0000_F00D, 1'b0, 4'h0, 32'h0);
    do_mem("lw",  OP_LW,  32'h0000_010C, 32'h0, 5'd11, 1'b1, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h0);
    do_mem("sh",  OP_SH,  32'h0000_0202, 32'hABCD_1234, 5'd12, 1'b1, 2, 32'h0, 32'h0, 1'b1, 4'b1100, 32'h1234_1234);
    do_mem("sb",  OP_SB,  32'h0000_0301, 32'h1234_565A, 5'd13, 1'b1, 1, 32'h0, 32'h0, 1'b1, 4'b0010, 32'h5A5A_5A5A);
    do_mem("sw",  OP_SW,  32'h0000_0400, 32'h1122_3344, 5'd14, 1'b1, 1, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h1122_3344);

    // Misaligned word and halfword accesses.
    issue(OP_LW, 32'h0000_0101, 32'h0, 5'd15, 1'b1);
    @(negedge clk);
    check("mis_lw_err", 32'(misalign_err), 32'd1);
    check("mis_lw_no_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("mis_lw_wb", 32'(wb_valid), 32'd0);
    check("mis_lw_ready", 32'(ready_in), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_lw_pulse", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    issue(OP_SH, 32'h0000_0201, 32'h0, 5'd16, 1'b1);
    @(negedge clk);
    check("mis_sh_err", 32'(misalign_err), 32'd1);
    check("mis_sh_no_req", 32'(dmem_bus.dmem_req), 32'd0);
    @(posedge clk); #1;

    // Reset in the second WAIT cycle abandons the load.
    issue(OP_LW, 32'h0000_0100, 32'h0, 5'd17, 1'b1);
    @(negedge clk);
    check("rstw_req_c1", 32'(dmem_bus.dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rstw_ready", 32'(ready_in), 32'd1);
    check("rstw_wb", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    do_mem("post_rst_lw", OP_LW, 32'h0000_0104, 32'h0, 5'd18, 1'b1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0);

`ifdef MEM_TIMEOUT_EN
    begin
      int unsigned low = 0;
      logic seen = 1'b0;
      issue(OP_LW, 32'h0000_0108, 32'h0, 5'd19, 1'b1);
      for (int unsigned i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus_timeout) seen = 1'b1;
        else if (!ready_in) low++;
        @(posedge clk); #1;
      end
      check("tmo_seen", 32'(seen), 32'd1);
      check("tmo_wait_cycles", low, TO);
      @(negedge clk);
      check("tmo_pulse", 32'(bus_timeout), 32'd0);
      check("tmo_req", 32'(dmem_bus.dmem_req), 32'd0);
      check("tmo_ready", 32'(ready_in), 32'd1);
      @(posedge clk); #1;
    end
    do_mem("ack_at_expiry", OP_LW, 32'h0000_0110, 32'h0, 5'd20, 1'b1, TO, 32'h0123_4567, 32'h0123_4567, 1'b0, 4'h0, 32'h0);
`else
    do_mem("long_wait", OP_LBU, 32'h0000_0112, 32'h0, 5'd21, 1'b1, 40, 32'h0077_0000, 32'h0000_0077, 1'b0, 4'h0, 32'h0);
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
